// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller.
package serial_adder_ctrl_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// 1-bit full adder used as the per-cycle datapath of the serial adder.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract controller, one full-adder step per cycle, LSB first.
// Define SERIAL_ADDER_OVF_EN to build the registered signed-overflow flag.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             sub_q;
    logic             carry_q;
    logic             carry_out_q;
    logic             busy_q;
    logic             done_q;

    logic bit_a;
    logic bit_b;
    logic bit_s;
    logic bit_co;
    logic last_bit;

    assign bit_a    = a_q[cnt_q[IdxW-1:0]];
    // Subtraction adds the one's complement of B; the +1 comes from the preloaded carry.
    assign bit_b    = b_q[cnt_q[IdxW-1:0]] ^ sub_q;
    assign last_bit = (state_q == StBusy) && (cnt_q == LastCnt);

    fulladder u_fulladder (
        .a_i  (bit_a),
        .b_i  (bit_b),
        .ci_i (carry_q),
        .s_o  (bit_s),
        .co_o (bit_co)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        sub_q   <= sub_i;
                        carry_q <= sub_i;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                        busy_q  <= 1'b1;
                    end
                end
                StBusy: begin
                    // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
                    sum_q   <= {bit_s, sum_q[WIDTH-1:1]};
                    carry_q <= bit_co;
                    cnt_q   <= cnt_q + CntW'(1);
                    if (last_bit) begin
                        carry_out_q <= bit_co;
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the last bit carry_q is the carry into the MSB.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= carry_q ^ bit_co;
        end
    end

    assign overflow_o = ovf_q;
`else
    assign overflow_o = 1'b0;
`endif

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_out_q;

endmodule
